// File: rtl/input_pixel_feeder_if.sv
// Pixel feeder stream bundle: byte input handshake plus FWFT pixel-word output.
// The slave side is the feeder itself; the master side is the byte source and
// pixel consumer.
`timescale 1ns/1ps
interface input_pixel_feeder_if #(
   parameter int IN_CHANNEL = 3
);
   logic [7:0]              s_data;
   logic                    s_valid;
   logic                    s_ready;
   logic                    fifo_rd_en;
   logic [8*IN_CHANNEL-1:0] o_data;
   logic                    o_valid;
   logic                    o_last;

   modport master (
      output s_data, s_valid, fifo_rd_en,
      input  s_ready, o_data, o_valid, o_last
   );

   modport slave (
      input  s_data, s_valid, fifo_rd_en,
      output s_ready, o_data, o_valid, o_last
   );
endinterface

// File: rtl/input_pixel_feeder.sv
// Packs a channel-interleaved byte stream into pixel words, buffers them in a
// first-word-fall-through FIFO and bounds each frame to IN_WIDTH*IN_HEIGHT pixels.
`timescale 1ns/1ps
module input_pixel_feeder #(
   parameter int IN_CHANNEL = 3,
   parameter int IN_WIDTH   = 256,
   parameter int IN_HEIGHT  = 256,
   parameter int FIFO_DEPTH = 16,
   parameter int AF_THRESH  = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input_pixel_feeder_if.slave  pix,
   output logic                 almost_full,
   output logic                 busy,
   output logic                 frame_done
);
   localparam int PIXELS = IN_WIDTH * IN_HEIGHT;
   localparam int BYTES  = PIXELS * IN_CHANNEL;
   localparam int BCW    = $clog2(BYTES) + 1;
   localparam int PCW    = $clog2(PIXELS) + 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CCW    = (IN_CHANNEL > 1) ? $clog2(IN_CHANNEL) : 1;
   localparam int DW     = 8 * IN_CHANNEL;

   localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [PCW-1:0] LAST_PIX  = PCW'(PIXELS - 1);
   localparam logic [CCW-1:0] LAST_CH   = CCW'(IN_CHANNEL - 1);
   localparam logic [AW:0]    FULL_CNT  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]    AF_CNT    = (AW+1)'(AF_THRESH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]     state_reg, state_next;
   logic [CCW-1:0] ch_cnt_reg;
   logic [DW-1:0]  pack_reg;
   logic [BCW-1:0] in_byte_cnt_reg;
   logic [PCW-1:0] out_pix_cnt_reg;

   logic [DW-1:0]  fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]    count_reg, count_next;
   logic           af_reg;

   logic           flush, fifo_full, fifo_empty, out_active;
   logic           ready_int, valid_int, accept, push, pop;
   logic [DW-1:0]  push_word;

   // abort only matters while a frame is in progress
   assign flush      = abort && (state_reg != ST_IDLE);
   assign fifo_full  = (count_reg == FULL_CNT);
   assign fifo_empty = (count_reg == '0);
   assign out_active = (state_reg == ST_STREAM) || (state_reg == ST_DRAIN);

   assign ready_int  = (state_reg == ST_STREAM) && !fifo_full;
   assign valid_int  = !fifo_empty && out_active;
   assign accept     = pix.s_valid && ready_int;
   assign push       = accept && (ch_cnt_reg == LAST_CH);
   assign pop        = valid_int && pix.fifo_rd_en;

   assign pix.s_ready = ready_int;
   assign pix.o_valid = valid_int;
   assign pix.o_data  = valid_int ? fifo_mem[rd_ptr_reg] : '0;
   assign pix.o_last  = valid_int && (out_pix_cnt_reg == LAST_PIX);

   assign almost_full = af_reg;
   assign busy        = (state_reg != ST_IDLE);
   assign frame_done  = (state_reg == ST_DONE);

   // the last channel byte bypasses the packer so the word is pushed the same cycle
   always_comb begin
      push_word      = pack_reg;
      push_word[7:0] = pix.s_data;
   end

   // frame sequencing; a flush overrides every other transition
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start) state_next = ST_STREAM;
         ST_STREAM: if (accept && (in_byte_cnt_reg == LAST_BYTE)) state_next = ST_DRAIN;
         ST_DRAIN:  if (pop && (out_pix_cnt_reg == LAST_PIX)) state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
      if (flush) state_next = ST_IDLE;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // byte packer and frame counters; cleared at frame start and on flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_cnt_reg      <= '0;
         pack_reg        <= '0;
         in_byte_cnt_reg <= '0;
         out_pix_cnt_reg <= '0;
      end else if (flush || ((state_reg == ST_IDLE) && start)) begin
         ch_cnt_reg      <= '0;
         pack_reg        <= '0;
         in_byte_cnt_reg <= '0;
         out_pix_cnt_reg <= '0;
      end else begin
         if (accept) begin
            for (int i = 0; i < IN_CHANNEL; i++) begin
               if (ch_cnt_reg == CCW'(i)) pack_reg[DW-1-8*i -: 8] <= pix.s_data;
            end
            ch_cnt_reg      <= push ? '0 : ch_cnt_reg + CCW'(1);
            in_byte_cnt_reg <= in_byte_cnt_reg + BCW'(1);
         end
         if (pop) out_pix_cnt_reg <= out_pix_cnt_reg + PCW'(1);
      end
   end

   // FIFO occupancy after this cycle's push/pop; push is already blocked at full
   always_comb begin
      count_next = count_reg;
      if (flush)              count_next = '0;
      else if (push && !pop)  count_next = count_reg + (AW+1)'(1);
      else if (pop && !push)  count_next = count_reg - (AW+1)'(1);
   end

   // FIFO storage, left unreset so it can map onto RAM
   always_ff @(posedge clk) begin
      if (push && !flush) fifo_mem[wr_ptr_reg] <= push_word;
   end

   // FIFO pointers, occupancy and the registered almost-full flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         af_reg     <= 1'b0;
      end else begin
         if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_next;
         af_reg    <= (count_next >= AF_CNT);
      end
   end
endmodule

// File: tb/tb_input_pixel_feeder.sv
// Self-checking bench for input_pixel_feeder on a 4x8-pixel frame.
`timescale 1ns/1ps
module tb_input_pixel_feeder;
   localparam int CH     = 3;
   localparam int W      = 4;
   localparam int H      = 8;
   localparam int DEPTH  = 16;
   localparam int AF     = 12;
   localparam int PIXELS = W * H;
   localparam int BYTES  = PIXELS * CH;

   logic clk = 1'b0;
   logic rst_n, start, abort, almost_full, busy, frame_done;
   int   checks = 0;
   int   errors = 0;

   input_pixel_feeder_if #(.IN_CHANNEL(CH)) pif ();

   input_pixel_feeder #(
      .IN_CHANNEL(CH), .IN_WIDTH(W), .IN_HEIGHT(H),
      .FIFO_DEPTH(DEPTH), .AF_THRESH(AF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .pix(pif.slave),
      .almost_full(almost_full), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  b0, b1, b2;
      logic [23:0] exp_word;
   } vec_t;
   vec_t vecs [6];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard = 0;
      bit taken = 1'b0;
      pif.s_valid = 1'b1;
      pif.s_data  = b;
      do begin
         taken = pif.s_ready;
         tick();
         guard++;
      end while (!taken && guard < 50);
      pif.s_valid = 1'b0;
      if (!taken) chk("send_timeout", 0, 1);
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 5 + 3);
   endfunction

   function automatic logic [23:0] word_of(input int k);
      return {pat(3*k), pat(3*k+1), pat(3*k+2)};
   endfunction

   // one full frame against a transaction-level model: occupancy is simply
   // words written minus words read, and words come out in write order
   task automatic run_frame(input int pv, input int pr, input string tag);
      logic [7:0] fb [BYTES];
      int  acc = 0, pops = 0, occ, cyc = 0;
      bit  sv, rd, exp_ready, exp_valid;
      for (int i = 0; i < BYTES; i++) fb[i] = 8'($urandom);
      pulse_start();
      while (pops < PIXELS && cyc < 5000) begin
         occ       = acc / CH - pops;
         exp_ready = (acc < BYTES) && (occ < DEPTH);
         exp_valid = (occ > 0);
         chk("s_ready", pif.s_ready, exp_ready);
         chk("o_valid", pif.o_valid, exp_valid);
         chk("almost_full", almost_full, occ >= AF);
         chk("busy", busy, 1);
         chk("frame_done_early", frame_done, 0);
         if (exp_valid) begin
            chk("o_data", pif.o_data, {fb[3*pops], fb[3*pops+1], fb[3*pops+2]});
            chk("o_last", pif.o_last, pops == PIXELS - 1);
         end
         sv = ($urandom_range(99) < pv);
         rd = ($urandom_range(99) < pr);
         pif.s_valid    = sv;
         pif.s_data     = (acc < BYTES) ? fb[acc] : 8'($urandom);
         pif.fifo_rd_en = rd;
         start          = (cyc == 3);
         tick();
         if (sv && exp_ready) acc++;
         if (exp_valid && rd) pops++;
         cyc++;
      end
      pif.s_valid = 1'b0;
      pif.fifo_rd_en = 1'b0;
      start = 1'b0;
      chk("frame_pops", pops, PIXELS);
      chk("frame_done", frame_done, 1);
      chk("done_o_valid", pif.o_valid, 0);
      chk("done_s_ready", pif.s_ready, 0);
      tick();
      chk("frame_done_pulse", frame_done, 0);
      chk("busy_after_done", busy, 0);
      if (pops < PIXELS) do_abort();
      $display("frame %s: bytes=%0d pops=%0d cycles=%0d", tag, acc, pops, cyc);
   endtask

   initial begin
      vecs[0] = '{8'h11, 8'h22, 8'h33, 24'h112233};
      vecs[1] = '{8'h00, 8'h00, 8'h00, 24'h000000};
      vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
      vecs[3] = '{8'h80, 8'h01, 8'h7F, 24'h80017F};
      vecs[4] = '{8'hA5, 8'h5A, 8'hC3, 24'hA55AC3};
      vecs[5] = '{8'h01, 8'h02, 8'h03, 24'h010203};

      // reset held with traffic present
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      pif.s_valid = 1'b1; pif.s_data = 8'hAA; pif.fifo_rd_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", pif.s_ready, 0);
      chk("rst_o_valid", pif.o_valid, 0);
      chk("rst_o_data", pif.o_data, 0);
      chk("rst_o_last", pif.o_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_almost_full", almost_full, 0);
      chk("rst_frame_done", frame_done, 0);
      $display("reset: s_ready=%0d o_valid=%0d busy=%0d", pif.s_ready, pif.o_valid, busy);
      pif.s_valid = 1'b0; pif.fifo_rd_en = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("idle_s_ready", pif.s_ready, 0);

      // packing and FWFT latency
      pulse_start();
      chk("stream_busy", busy, 1);
      send_byte(8'h11);
      send_byte(8'h22);
      chk("pack_no_partial", pif.o_valid, 0);
      send_byte(8'h33);
      chk("pack_valid_latency", pif.o_valid, 1);
      chk("pack_word0", pif.o_data, 24'h112233);
      send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
      chk("pack_head_held", pif.o_data, 24'h112233);
      pif.fifo_rd_en = 1'b1;
      tick();
      chk("pack_word1_valid", pif.o_valid, 1);
      chk("pack_word1", pif.o_data, 24'h445566);
      tick();
      chk("pack_occ2_empty", pif.o_valid, 0);
      tick();
      chk("underflow_ignored", pif.o_valid, 0);
      pif.fifo_rd_en = 1'b0;
      send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
      chk("after_underflow", pif.o_data, 24'h778899);
      $display("pack: two words popped, head after empty read=%h", pif.o_data);
      do_abort();
      chk("abort_idle", busy, 0);

      // table of pixel triples inside one frame
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         send_byte(vecs[i].b0);
         send_byte(vecs[i].b1);
         send_byte(vecs[i].b2);
         chk("vec_valid", pif.o_valid, 1);
         chk("vec_word", pif.o_data, vecs[i].exp_word);
         $display("vec %0d: o_data=%h expected=%h", i, pif.o_data, vecs[i].exp_word);
         pif.fifo_rd_en = 1'b1;
         tick();
         pif.fifo_rd_en = 1'b0;
         chk("vec_popped", pif.o_valid, 0);
      end
      do_abort();

      // fill to full, backpressure, then a single pop reopens the input
      pulse_start();
      for (int n = 1; n <= DEPTH * CH; n++) begin
         send_byte(pat(n - 1));
         chk("fill_almost_full", almost_full, (n / CH) >= AF);
      end
      chk("full_s_ready", pif.s_ready, 0);
      pif.s_valid = 1'b1; pif.s_data = pat(DEPTH * CH);
      tick(); tick();
      chk("full_hold_s_ready", pif.s_ready, 0);
      pif.s_valid = 1'b0;
      chk("full_head", pif.o_data, word_of(0));
      pif.fifo_rd_en = 1'b1;
      tick();
      pif.fifo_rd_en = 1'b0;
      chk("pop_reopens_s_ready", pif.s_ready, 1);
      chk("pop_af_still", almost_full, 1);
      chk("pop_next_head", pif.o_data, word_of(1));
      for (int n = DEPTH * CH; n < DEPTH * CH + CH; n++) send_byte(pat(n));
      for (int k = 1; k <= DEPTH; k++) begin
         chk("drain_valid", pif.o_valid, 1);
         chk("drain_word", pif.o_data, word_of(k));
         pif.fifo_rd_en = 1'b1;
         tick();
      end
      pif.fifo_rd_en = 1'b0;
      chk("drain_empty", pif.o_valid, 0);
      chk("drain_af_clear", almost_full, 0);
      $display("full: %0d words drained in order after backpressure", DEPTH);
      do_abort();

      // abort mid-word discards everything
      pulse_start();
      for (int n = 0; n < 7; n++) send_byte(pat(n));
      chk("pre_abort_valid", pif.o_valid, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_o_valid", pif.o_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_frame_done", frame_done, 0);
      chk("abort_s_ready", pif.s_ready, 0);
      tick();
      chk("abort_no_done_later", frame_done, 0);
      $display("abort: o_valid=%0d busy=%0d", pif.o_valid, busy);
      run_frame(100, 100, "after-abort");

      // asynchronous reset in the middle of a frame
      pulse_start();
      for (int n = 0; n < 4; n++) send_byte(pat(n));
      chk("pre_reset_valid", pif.o_valid, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy", busy, 0);
      chk("async_rst_o_valid", pif.o_valid, 0);
      chk("async_rst_o_data", pif.o_data, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      $display("async reset: busy=%0d o_valid=%0d", busy, pif.o_valid);

      run_frame(100, 100, "full-rate");
      run_frame(60, 70, "random-a");
      run_frame(75, 40, "random-b");
      run_frame(90, 15, "backpressure");
      run_frame(30, 95, "starved");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
